// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if -- bundle for the two-requester shared 16-bit path.
//   Requester side : req_a/req_b, last_a/last_b, a/b data words
//   Consumer side  : r_ready in; r, r_valid out
//   Arbiter status : gnt_a/gnt_b (one-hot or zero), s (mux select, 0=A 1=B)
// slave modport is used by the arbiter, master by whoever drives it.
interface mux_arbiter_if;
    logic        req_a;
    logic        req_b;
    logic        last_a;
    logic        last_b;
    logic [15:0] a;
    logic [15:0] b;
    logic        r_ready;
    logic        gnt_a;
    logic        gnt_b;
    logic        s;
    logic [15:0] r;
    logic        r_valid;

    modport slave (
        input  req_a, req_b, last_a, last_b, a, b, r_ready,
        output gnt_a, gnt_b, s, r, r_valid
    );

    modport master (
        output req_a, req_b, last_a, last_b, a, b, r_ready,
        input  gnt_a, gnt_b, s, r, r_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter -- grants one of two requesters a shared 16-bit 2:1 mux and
// registers the selected word into a one-entry output slot (r/r_valid).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_arbiter_if.slave (requests, data, grants, select, result)
// Bursts end on an accepted beat with LAST, on the requester dropping REQ,
// or after 16 accepted beats. IDLE always separates two bursts.
// Optional build macro MUX_ARBITER_ROUND_ROBIN_EN: ties go to the requester
// that was not served last; otherwise ties always go to A.
module mux_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mux_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        ptr_b_q;     // 1: B was served last
    logic        s_q;         // select value held through IDLE
    logic [15:0] r_q;
    logic        rv_q;

    logic        gnt_req, gnt_last, slot_free, accept, end_burst, tie_to_a;
    logic [15:0] sel_word;

`ifdef MUX_ARBITER_ROUND_ROBIN_EN
    assign tie_to_a = ptr_b_q;
`else
    // Fixed priority: the pointer is still tracked but plays no role.
    logic ptr_unused;
    assign ptr_unused = ptr_b_q;
    assign tie_to_a   = 1'b1;
`endif

    // Grant and select are pure decodes of the state; select only remembers
    // its previous value while idle.
    assign bus.gnt_a   = (state_q == GRANT_A);
    assign bus.gnt_b   = (state_q == GRANT_B);
    assign bus.s       = (state_q == GRANT_B) | ((state_q == IDLE) & s_q);
    assign bus.r       = r_q;
    assign bus.r_valid = rv_q;

    assign sel_word = bus.s ? bus.b : bus.a;

    always_comb begin
        gnt_req   = 1'b0;
        gnt_last  = 1'b0;
        state_d   = state_q;
        slot_free = !rv_q || bus.r_ready;
        case (state_q)
            GRANT_A: begin gnt_req = bus.req_a; gnt_last = bus.last_a; end
            GRANT_B: begin gnt_req = bus.req_b; gnt_last = bus.last_b; end
            default: ;
        endcase
        accept = gnt_req && slot_free;

        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || tie_to_a)) state_d = GRANT_A;
                else if (bus.req_b)                        state_d = GRANT_B;
            end
            GRANT_A, GRANT_B: begin
                // Abort, LAST, or 16th beat (counter about to wrap) releases.
                if (!gnt_req || (accept && (gnt_last || cnt_q == 4'hF)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        end_burst = (state_q != IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'h0;
            ptr_b_q <= 1'b1;          // A wins the first tie
            s_q     <= 1'b0;
            r_q     <= 16'h0000;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= bus.s;

            if (accept) begin
                r_q  <= sel_word;
                rv_q <= 1'b1;
            end else if (bus.r_ready) begin
                rv_q <= 1'b0;
            end

            if (end_burst)   cnt_q <= 4'h0;
            else if (accept) cnt_q <= cnt_q + 4'h1;

            if (end_burst) ptr_b_q <= (state_q == GRANT_B);
        end
    end
endmodule
